// File: rtl/axi_rw_arbiter.sv
// Shares one AXI3 master port between the instruction-fetch and data ports of the nocache core.
// One outstanding transaction at a time; reads are single-beat 32-bit, stores issue AW and W together.
module axi_rw_arbiter #(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned INST_ID = 0,
  parameter int unsigned DATA_ID = 1
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch port
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_valid,
  output logic [31:0]       inst_rdata,
  output logic              inst_err,
  // data port
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              data_err,
  // AXI3 read address
  output logic [ID_W-1:0]   arid,
  output logic [31:0]       araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  // AXI3 read data
  input  logic [ID_W-1:0]   rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI3 write address
  output logic [ID_W-1:0]   awid,
  output logic [31:0]       awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  // AXI3 write data
  output logic [ID_W-1:0]   wid,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI3 write response
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B} state_t;

  state_t state;
  logic   rr_last_data;  // 1: data port won the last grant
  logic   owner_data;    // 1: current transaction belongs to the data port
  logic   grant_inst_c;
  logic   grant_data_c;
  logic   aw_done_c;
  logic   w_done_c;
  logic   unused_ids;

  // Ownership comes from owner_data, so the returned ids are not needed.
  assign unused_ids = ^{rid, bid};

  // Fixed single-beat, 32-bit, incrementing burst attributes.
  assign arlen   = LEN_W'(0);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awlen   = LEN_W'(0);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  // Round-robin grant: a lone requester wins; on contention the port that did not win last time wins.
  assign grant_inst_c = (state == IDLE) && !reset && inst_req && (!data_req || rr_last_data);
  assign grant_data_c = (state == IDLE) && !reset && data_req && (!inst_req || !rr_last_data);

  // addr_ok must acknowledge in the grant cycle itself, so it stays combinational.
  assign inst_addr_ok = grant_inst_c;
  assign data_addr_ok = grant_data_c;

  assign aw_done_c = !awvalid || awready;
  assign w_done_c  = !wvalid || wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_last_data <= 1'b1;
      owner_data   <= 1'b0;
      inst_valid   <= 1'b0;
      inst_rdata   <= 32'h0;
      inst_err     <= 1'b0;
      data_data_ok <= 1'b0;
      data_rdata   <= 32'h0;
      data_err     <= 1'b0;
      arid         <= ID_W'(0);
      araddr       <= 32'h0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awid         <= ID_W'(0);
      awaddr       <= 32'h0;
      awvalid      <= 1'b0;
      wid          <= ID_W'(0);
      wdata        <= 32'h0;
      wstrb        <= 4'h0;
      wlast        <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
    end else begin
      inst_valid   <= 1'b0;
      inst_err     <= 1'b0;
      data_data_ok <= 1'b0;
      data_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_inst_c || grant_data_c) begin
            owner_data   <= grant_data_c;
            rr_last_data <= grant_data_c;
            if (grant_data_c && data_wr) begin
              state   <= WR_AWW;
              awid    <= ID_W'(DATA_ID);
              awaddr  <= data_addr;
              awvalid <= 1'b1;
              wid     <= ID_W'(DATA_ID);
              wdata   <= data_wdata;
              wstrb   <= data_wstrb;
              wlast   <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RD_AR;
              arid    <= grant_data_c ? ID_W'(DATA_ID) : ID_W'(INST_ID);
              araddr  <= grant_data_c ? data_addr : inst_addr;
              arvalid <= 1'b1;
            end
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (rvalid && rlast) begin
            rready <= 1'b0;
            state  <= IDLE;
            if (owner_data) begin
              data_rdata   <= rdata;
              data_data_ok <= 1'b1;
              data_err     <= |rresp;
            end else begin
              inst_rdata <= rdata;
              inst_valid <= 1'b1;
              inst_err   <= |rresp;
            end
          end
        end
        WR_AWW: begin
          // AW and W retire independently; move on once both have handshaken.
          if (awready) awvalid <= 1'b0;
          if (wready) begin
            wvalid <= 1'b0;
            wlast  <= 1'b0;
          end
          if (aw_done_c && w_done_c) begin
            bready <= 1'b1;
            state  <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            bready       <= 1'b0;
            data_data_ok <= 1'b1;
            data_err     <= |bresp;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Self-checking bench for axi_rw_arbiter: directed and randomized transactions against a
// round-robin / single-outstanding reference model with an in-bench AXI slave.
module tb_axi_rw_arbiter;

  localparam int unsigned ID_W  = 4;
  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             inst_req, inst_addr_ok, inst_valid, inst_err;
  logic [31:0]      inst_addr, inst_rdata;
  logic             data_req, data_wr, data_addr_ok, data_data_ok, data_err;
  logic [3:0]       data_wstrb;
  logic [31:0]      data_addr, data_wdata, data_rdata;
  logic [ID_W-1:0]  arid, rid, awid, wid, bid;
  logic [31:0]      araddr, rdata, awaddr, wdata;
  logic [LEN_W-1:0] arlen, awlen;
  logic [2:0]       arsize, arprot, awsize, awprot;
  logic [1:0]       arburst, arlock, rresp, awburst, awlock, bresp;
  logic [3:0]       arcache, awcache, wstrb;
  logic             arvalid, arready, rlast, rvalid, rready;
  logic             awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_chk  = 0;
  int n_fail = 0;
  bit m_last_data;  // model: which port won the most recent grant

  always #5 clk = ~clk;

  axi_rw_arbiter #(.ID_W(ID_W), .LEN_W(LEN_W), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_valid(inst_valid), .inst_rdata(inst_rdata), .inst_err(inst_err),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .data_err(data_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One arbitration round plus the full AXI exchange for the winner.
  // da/db: cycles before arready/rvalid (read) or awready/wready (store); dc: cycles before bvalid.
  task automatic txn(input bit ireq, input bit dreq, input bit dwr,
                     input logic [31:0] iaddr, input logic [31:0] daddr, input logic [31:0] wd,
                     input logic [3:0] strb, input logic [31:0] rword, input logic [1:0] resp,
                     input int da, input int db, input int dc);
    bit win_data;
    bit is_store;
    logic [31:0] exp_addr;
    int last;
    inst_req = ireq; data_req = dreq; data_wr = dwr;
    inst_addr = iaddr; data_addr = daddr; data_wdata = wd; data_wstrb = strb;
    #1;
    if (!ireq && !dreq) begin
      chk("no_grant_when_idle", 32'({inst_addr_ok, data_addr_ok}), 32'h0);
      step();
      return;
    end
    win_data = dreq && (!ireq || !m_last_data);
    is_store = win_data && dwr;
    exp_addr = win_data ? daddr : iaddr;
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(ireq && !win_data));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(win_data));
    m_last_data = win_data;
    step();
    if (win_data) data_req = 1'b0; else inst_req = 1'b0;
    data_addr = $urandom; inst_addr = $urandom; data_wdata = $urandom;
    #1;
    chk("pulse_one_cycle", 32'({inst_valid, data_data_ok}), 32'h0);
    if (is_store) begin
      last = (da > db) ? da : db;
      for (int k = 0; k <= last; k++) begin
        if (k > 0) step();
        awready = (k == da); wready = (k == db);
        #1;
        chk("awvalid", 32'(awvalid), 32'(k <= da));
        chk("wvalid", 32'(wvalid), 32'(k <= db));
        chk("no_addr_ok_busy", 32'({inst_addr_ok, data_addr_ok}), 32'h0);
        if (k == da) begin
          chk("awaddr", awaddr, exp_addr);
          chk("awid", 32'(awid), 32'h1);
          chk("aw_len_size_burst", 32'({awlen, awsize, awburst}), 32'({8'h00, 3'b010, 2'b01}));
        end
        if (k == db) begin
          chk("wdata", wdata, wd);
          chk("wstrb_wlast_wid", 32'({wstrb, wlast, wid}), 32'({strb, 1'b1, 4'h1}));
        end
      end
      step();
      awready = 1'b0; wready = 1'b0;
      for (int k = 0; k <= dc; k++) begin
        if (k > 0) step();
        bvalid = (k == dc); bresp = resp; bid = 4'h1;
        #1;
        chk("bready", 32'(bready), 32'h1);
        chk("no_early_data_ok", 32'(data_data_ok), 32'h0);
      end
      step();
      bvalid = 1'b0;
      #1;
      chk("store_data_ok", 32'(data_data_ok), 32'h1);
      chk("store_err", 32'(data_err), 32'(resp != 2'b00));
      chk("store_no_inst_valid", 32'(inst_valid), 32'h0);
    end else begin
      for (int k = 0; k <= da; k++) begin
        if (k > 0) step();
        arready = (k == da);
        #1;
        chk("arvalid", 32'(arvalid), 32'h1);
        chk("no_addr_ok_busy", 32'({inst_addr_ok, data_addr_ok}), 32'h0);
        if (k == da) begin
          chk("araddr", araddr, exp_addr);
          chk("arid", 32'(arid), 32'(win_data));
          chk("ar_len_size_burst", 32'({arlen, arsize, arburst}), 32'({8'h00, 3'b010, 2'b01}));
        end
      end
      step();
      arready = 1'b0;
      for (int k = 0; k <= db; k++) begin
        if (k > 0) step();
        rvalid = (k == db); rdata = rword; rresp = resp; rlast = 1'b1; rid = 4'hF;
        #1;
        chk("rready_arvalid", 32'({rready, arvalid}), 32'h2);
        chk("no_early_pulse", 32'({inst_valid, data_data_ok}), 32'h0);
      end
      step();
      rvalid = 1'b0; rdata = $urandom;
      #1;
      chk("inst_valid", 32'(inst_valid), 32'(!win_data));
      chk("data_data_ok", 32'(data_data_ok), 32'(win_data));
      if (win_data) begin
        chk("data_rdata", data_rdata, rword);
        chk("data_err", 32'(data_err), 32'(resp != 2'b00));
      end else begin
        chk("inst_rdata", inst_rdata, rword);
        chk("inst_err", 32'(inst_err), 32'(resp != 2'b00));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h0; data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    arready = 1'b0; rid = '0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
    m_last_data = 1'b1;
    repeat (3) step();

    // reset state, with both requests already held
    chk("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'h0);
    chk("rst_pulses", 32'({inst_addr_ok, data_addr_ok, inst_valid, data_data_ok, inst_err, data_err}), 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_ids", 32'({arid, awid, wid}), 32'h0);
    reset = 1'b0;

    // both held from reset release: fetch, load, fetch
    txn(1, 1, 0, 32'h1C00_0000, 32'h8000_0010, 32'h0, 4'h0, 32'h1111_0001, 2'b00, 0, 0, 0);
    chk("first_winner_inst", 32'(m_last_data), 32'h0);
    txn(1, 1, 0, 32'h1C00_0004, 32'h8000_0010, 32'h0, 4'h0, 32'h2222_0002, 2'b00, 1, 1, 0);
    txn(1, 1, 0, 32'h1C00_0004, 32'h8000_0010, 32'h0, 4'h0, 32'h3333_0003, 2'b00, 0, 2, 0);
    data_req = 1'b0;

    // arready high while idle has no effect
    inst_req = 1'b0; arready = 1'b1;
    step();
    #1;
    chk("early_arready", 32'(arvalid), 32'h0);
    arready = 1'b0;

    // lone fetch, rvalid two cycles after R phase begins
    txn(1, 0, 0, 32'h1C00_0000, 32'h0, 32'h0, 4'h0, 32'h0280_0C0C, 2'b00, 0, 2, 0);
    // store with awready one cycle before wready, delayed B
    txn(0, 1, 1, 32'h0, 32'h8000_0020, 32'hDEAD_BEEF, 4'b0011, 32'h0, 2'b00, 0, 1, 2);
    // load with SLVERR
    txn(0, 1, 0, 32'h0, 32'h8000_0030, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b10, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          4'($urandom), $urandom, 2'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    inst_req = 1'b0; data_req = 1'b0;
    step();

    // reset during RD_R drops the transaction and any late response
    inst_req = 1'b1; inst_addr = 32'h1C00_0100;
    #1;
    chk("rst_test_grant", 32'(inst_addr_ok), 32'h1);
    step();
    inst_req = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    chk("rst_test_in_rd_r", 32'(rready), 32'h1);
    step();
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'({arvalid, rready, awvalid, wvalid, bready, inst_valid, data_data_ok}), 32'h0);
    chk("rst_mid_araddr", araddr, 32'h0);
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h5555_AAAA;
    step();
    reset = 1'b0;
    m_last_data = 1'b1;
    step();
    #1;
    chk("late_r_dropped", 32'({inst_valid, rready, data_data_ok}), 32'h0);
    chk("late_r_rdata", inst_rdata, 32'h0);
    rvalid = 1'b0;
    step();
    txn(1, 0, 0, 32'h1C00_0200, 32'h0, 32'h0, 4'h0, 32'h0123_4567, 2'b00, 0, 0, 0);
    inst_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
